// File: rtl/unary_pkg.sv
// Shared constants for the unary stream decoder and MAC blocks: FSM state encoding and
// window/width helpers.
package unary_pkg;

  localparam int unsigned DefaultLanes = 4;
  localparam int unsigned DefaultSize  = 6;

  // Legacy-compatible state encoding (IDLE, COLLECT, HOLD)
  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCollect = 2'd1;
  localparam logic [1:0] StHold    = 2'd2;

  function automatic int unsigned win_of(input int unsigned size);
    return 32'd1 << size;
  endfunction

  // A full window of ones yields exactly WIN, so one extra bit beyond SIZE is needed
  function automatic int unsigned cnt_width(input int unsigned size);
    return size + 32'd1;
  endfunction

endpackage

// File: rtl/unary_lane_count.sv
// One unary lane: ones counter plus optional thermometer-order checker
// (enabled by UNARY_THERM_CHECK_EN).
module unary_lane_count #(
  parameter int unsigned Size = unary_pkg::DefaultSize
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          en_i,
  input  logic          bit_i,
  output logic [Size:0] count_o,
  output logic          err_o
);
  import unary_pkg::*;

  localparam int unsigned CntW = cnt_width(Size);

  logic [CntW-1:0] count_q, count_d;

  // clear_i doubles as the first sample of a new window
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = CntW'(bit_i);
    end else if (en_i) begin
      count_d = count_q + CntW'(bit_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

`ifdef UNARY_THERM_CHECK_EN
  logic seen_zero_q, seen_zero_d;
  logic err_q, err_d;

  always_comb begin
    seen_zero_d = seen_zero_q;
    err_d       = err_q;
    if (clear_i) begin
      seen_zero_d = ~bit_i;
      err_d       = 1'b0;
    end else if (en_i) begin
      if (bit_i && seen_zero_q) begin
        err_d = 1'b1;
      end
      if (!bit_i) begin
        seen_zero_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seen_zero_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      seen_zero_q <= seen_zero_d;
      err_q       <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: rtl/unary_stream_decoder.sv
// Counts ones per lane over a 2^SIZE-sample window and holds the result until accepted.
// Thermometer checking per lane is enabled by defining UNARY_THERM_CHECK_EN.
module unary_stream_decoder #(
  parameter int unsigned LANES = unary_pkg::DefaultLanes,
  parameter int unsigned SIZE  = unary_pkg::DefaultSize
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [LANES-1:0]          in_bits,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*(SIZE+1)-1:0] out_data,
  output logic [LANES-1:0]          err
);
  import unary_pkg::*;

  localparam int unsigned CntW = cnt_width(SIZE);
  localparam int unsigned Win  = win_of(SIZE);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] sample_q, sample_d;
  logic            valid_q, valid_d;
  logic            clear, sample_en;

  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    clear     = 1'b0;
    sample_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          clear    = 1'b1;
          sample_d = CntW'(1);
          if (Win == 1) begin
            state_d = StHold;
            valid_d = 1'b1;
          end else begin
            state_d = StCollect;
          end
        end
      end
      StCollect: begin
        sample_en = 1'b1;
        sample_d  = sample_q + CntW'(1);
        if (sample_q == CntW'(Win - 1)) begin
          state_d = StHold;
          valid_d = 1'b1;
        end
      end
      StHold: begin
        // start is deliberately ignored here, even in the handshake cycle
        if (out_ready) begin
          state_d  = StIdle;
          valid_d  = 1'b0;
          sample_d = '0;
        end
      end
      default: begin
        state_d  = StIdle;
        valid_d  = 1'b0;
        sample_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign busy      = (state_q == StCollect) || (state_q == StHold);
  assign out_valid = valid_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    unary_lane_count #(
      .Size (SIZE)
    ) u_lane (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .clear_i (clear),
      .en_i    (sample_en),
      .bit_i   (in_bits[k]),
      .count_o (out_data[k*CntW +: CntW]),
      .err_o   (err[k])
    );
  end

endmodule

// File: tb/tb_unary_stream_decoder.sv
// Directed bench for unary_stream_decoder at SIZE=3, LANES=2 (WIN=8).
module tb_unary_stream_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [1:0] in_bits;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] err;

  int tests = 0;
  int fails = 0;

`ifdef UNARY_THERM_CHECK_EN
  localparam logic [1:0] ErrWinC = 2'b01;
`else
  localparam logic [1:0] ErrWinC = 2'b00;
`endif

  always #5 clk = ~clk;

  unary_stream_decoder #(
    .LANES (2),
    .SIZE  (3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .in_bits   (in_bits),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives 8 samples, first bit of each pattern (MSB) is sample 1; checks latency.
  task automatic run_window(input logic [7:0] l0, input logic [7:0] l1, input bit start_mid);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j > 0) check("busy_collect", {31'd0, busy}, 32'd1);
      if (j == 7) check("valid_early", {31'd0, out_valid}, 32'd0);
      start   = (j == 0) || (start_mid && j == 3);
      in_bits = {l1[7-j], l0[7-j]};
    end
    @(negedge clk);
    start   = 1'b0;
    in_bits = 2'b00;
    check("valid_latency", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic handshake(input int hold, input logic [7:0] exp_data, input logic [1:0] exp_err,
                           input bit start_hs);
    check("data", {24'd0, out_data}, {24'd0, exp_data});
    check("err", {30'd0, err}, {30'd0, exp_err});
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", {24'd0, out_data}, {24'd0, exp_data});
      check("hold_busy", {31'd0, busy}, 32'd1);
    end
    out_ready = 1'b1;
    start     = start_hs;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    check("valid_drop", {31'd0, out_valid}, 32'd0);
    check("idle_after_hs", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    in_bits   = 2'b00;
    out_ready = 1'b0;
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_err", {30'd0, err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // lane0 = 3 ones, lane1 = 8 ones
    run_window(8'b11100000, 8'b11111111, 1'b0);
    handshake(0, 8'h83, 2'b00, 1'b0);
    repeat (2) @(negedge clk);
    check("idle_retain", {24'd0, out_data}, 32'h83);
    check("idle_valid", {31'd0, out_valid}, 32'd0);

    // all-zero window, stalled consumer, start mid-window and in handshake cycle
    run_window(8'b00000000, 8'b00000000, 1'b1);
    handshake(5, 8'h00, 2'b00, 1'b1);
    @(negedge clk);
    check("hs_start_ignored", {31'd0, busy}, 32'd0);

    // lane0 breaks thermometer order; back-to-back with next window
    run_window(8'b10100000, 8'b11110000, 1'b0);
    handshake(0, 8'h42, ErrWinC, 1'b0);
    run_window(8'b11111111, 8'b00000000, 1'b0);
    handshake(0, 8'h08, 2'b00, 1'b0);
    check("retain_b2b", {24'd0, out_data}, 32'h08);

    // reset at sample 4 discards the window
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      start   = (j == 0);
      in_bits = 2'b11;
    end
    @(negedge clk);
    start = 1'b0;
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_data", {24'd0, out_data}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_err", {30'd0, err}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    in_bits = 2'b00;
    repeat (10) @(negedge clk);
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_data", {24'd0, out_data}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/unary_stream_decoder.md
UNARY_STREAM_DECODER -- requirements
Module: unary_stream_decoder

Interface
REQ-001 SHALL have parameter LANES, default 4: number of parallel unary lanes.
REQ-002 SHALL have parameter SIZE, default 6: binary width per lane; window WIN = 2^SIZE samples.
REQ-003 SHALL have port clk  input  1  clock; reset reset_n, asynchronous, active-low; clock clk.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  begin sampling window; sampled only in IDLE.
REQ-006 SHALL have port in_bits  input  LANES  one temporal-unary bit per lane per cycle.
REQ-007 SHALL have port busy  output  1  high in COLLECT or HOLD.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port out_data  output  LANES*(SIZE+1)  lane k count at bits [(k+1)*(SIZE+1)-1 : k*(SIZE+1)].
REQ-011 SHALL have port err  output  LANES  per-lane thermometer violation flag, valid with out_valid.

Function
REQ-012 SHALL implement FSM IDLE -> COLLECT -> HOLD -> IDLE.
REQ-013 IDLE: start=1 SHALL sample in_bits that same cycle as sample 1, clear lane counts, and enter COLLECT.
REQ-014 COLLECT SHALL add in_bits[k] to lane k count every cycle until WIN samples total, including the start cycle.
REQ-015 After sample WIN, SHALL enter HOLD and assert out_valid on the next cycle; latency = WIN cycles from start to out_valid.
REQ-016 Lane count range SHALL be 0..WIN in SIZE+1 bits, with no wrap; an all-ones window SHALL yield exactly WIN.
REQ-017 HOLD SHALL keep out_valid, out_data and err stable until out_valid && out_ready.
REQ-018 On handshake, SHALL return to IDLE with out_valid=0 next cycle.
REQ-019 start in COLLECT or HOLD SHALL be ignored, including a start coinciding with the handshake cycle.
REQ-020 out_data SHALL retain its last value in IDLE; only the next start SHALL clear the counts.
REQ-021 busy SHALL be combinational from state: 1 in COLLECT or HOLD, 0 in IDLE.

Reset
REQ-022 reset_n low SHALL force IDLE, out_valid=0, out_data=0, err=0, sample counter=0, all immediately.
REQ-023 Reset mid-COLLECT or mid-HOLD SHALL discard the window; no out_valid is produced for it.

Configuration
REQ-024 Macro UNARY_THERM_CHECK_EN defined: each lane SHALL track whether a 0 has been sampled in the window; a later 1 SHALL set that lane's err, sticky until the next start.
REQ-025 Macro undefined: err SHALL be tied to 0 with no check logic; counts SHALL be unaffected either way.

Structure
REQ-026 Package unary_pkg SHALL hold the state enum (IDLE, COLLECT, HOLD) and the WIN/width helper constants, shared with the MAC block.
REQ-027 Per-lane logic (count register, thermometer tracker) SHALL be sub-module unary_lane_count, instantiated LANES times in a generate loop.
REQ-028 A single shared sample counter of SIZE+1 bits SHALL set the window length.

Verification (SIZE=3, LANES=2, WIN=8)
REQ-029 start with lane0=11100000 and lane1=11111111 over the window -> out_valid 8 cycles after start, lane0=3, lane1=8, err=00.
REQ-030 all-zero window -> out_data=0; out_ready held low 5 cycles -> out_valid and out_data stable, busy=1 throughout.
REQ-031 start pulsed during COLLECT and in the handshake cycle -> ignored; IDLE after handshake, next start begins a fresh window.
REQ-032 reset_n low at sample 4 -> out_valid=0, out_data=0, IDLE; no result for that window.
REQ-033 lane0=10100000 with macro defined -> count 2, err[0]=1; macro undefined -> count 2, err=0.
REQ-034 two back-to-back windows with out_ready=1 -> second result independent of first; err cleared by second start.
